// File: rtl/priority_display_pkg.sv
// Shared constants for the priority-code decode/display path: seven-segment
// patterns ({a,b,c,d,e,f,g,dp}, bit 7 = a), digit count and dp bit position.
package priority_display_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int NUM_DIGITS = 4;
  localparam int DP_BIT     = 0;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to seven-segment pattern; values above 9 or an
// asserted blank flag give a dark digit. dp is always left clear here.
module seg7_decode
  import priority_display_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      unique case (value)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/priority_decode_display.sv
// Accepts priority codes, drives a one-hot LED decode, and scans a BCD accept
// count (left group) and a four-deep code history (right group) onto two
// 4-digit displays. Define DP_NEWEST_EN to light dp on the newest history digit.
module priority_decode_display
  import priority_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       n_EN,
  input  logic       code_valid,
  input  logic [2:0] code,
  output logic       code_ready,
  output logic [7:0] led,
  output logic [7:0] a_to_g_left,
  output logic [7:0] a_to_g_right,
  output logic [3:0] leftseg,
  output logic [3:0] rightseg
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic                  xfer;
  logic [DIV_W-1:0]      div_cnt;
  logic [1:0]            idx;
  logic [1:0]            idx_next;
  logic                  div_term;
  logic [15:0]           count_bcd;
  logic [2:0]            hist [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] hist_vld;
  logic [2:0]            last_code;
  logic                  have_code;
  logic [3:0]            left_val;
  logic [7:0]            left_pat;
  logic [7:0]            right_pat;
  logic [7:0]            right_pat_dp;
  logic                  right_dp;
  logic [7:0]            led_p1;
  logic [7:0]            seg_left_p1;
  logic [7:0]            seg_right_p1;
  logic [3:0]            sel_p1;

  assign code_ready = ~n_EN;
  assign xfer       = code_valid & code_ready;

  // Segment registers load the digit that becomes selected on this edge, so
  // select and segment data always change together.
  assign div_term = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign idx_next = div_term ? idx + 2'd1 : idx;
  assign left_val = count_bcd[{idx_next, 2'b00} +: 4];

  seg7_decode u_left_dec (
    .value (left_val),
    .blank (1'b0),
    .seg   (left_pat)
  );

  seg7_decode u_right_dec (
    .value ({1'b0, hist[idx_next]}),
    .blank (~hist_vld[idx_next]),
    .seg   (right_pat)
  );

`ifdef DP_NEWEST_EN
  assign right_dp = (idx_next == 2'd0) & hist_vld[0] & ~n_EN;
`else
  assign right_dp = 1'b0;
`endif

  always_comb begin
    right_pat_dp         = right_pat;
    right_pat_dp[DP_BIT] = right_dp;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      sel_p1  <= 4'b0001;
    end else begin
      div_cnt <= div_term ? '0 : div_cnt + DIV_W'(1);
      idx     <= idx_next;
      sel_p1  <= 4'b0001 << idx_next;
    end
  end

  // Accepted-code state: history, count, last code.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_bcd <= '0;
      hist_vld  <= '0;
      last_code <= 3'd0;
      have_code <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) hist[i] <= 3'd0;
    end else if (xfer) begin
      count_bcd <= bcd_inc(count_bcd);
      hist_vld  <= {hist_vld[NUM_DIGITS-2:0], 1'b1};
      last_code <= code;
      have_code <= 1'b1;
      hist[0]   <= code;
      for (int i = 1; i < NUM_DIGITS; i++) hist[i] <= hist[i-1];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      led_p1       <= 8'h00;
      seg_left_p1  <= SEG_BLANK;
      seg_right_p1 <= SEG_BLANK;
    end else begin
      if (n_EN)           led_p1 <= 8'h00;
      else if (xfer)      led_p1 <= 8'b1 << code;
      else if (have_code) led_p1 <= 8'b1 << last_code;
      else                led_p1 <= 8'h00;
      seg_left_p1  <= n_EN ? SEG_BLANK : left_pat;
      seg_right_p1 <= n_EN ? SEG_BLANK : right_pat_dp;
    end
  end

  assign led          = led_p1;
  assign a_to_g_left  = seg_left_p1;
  assign a_to_g_right = seg_right_p1;
  assign leftseg      = sel_p1;
  assign rightseg     = sel_p1;

endmodule

// File: tb/tb_priority_decode_display.sv
// Directed and randomized bench for priority_decode_display (SCAN_DIV=4) with
// an arithmetic reference model of count, history and scan position.
module tb_priority_decode_display;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       n_EN = 1'b1;
  logic       code_valid = 1'b0;
  logic [2:0] code = 3'd0;
  logic       code_ready;
  logic [7:0] led;
  logic [7:0] a_to_g_left;
  logic [7:0] a_to_g_right;
  logic [3:0] leftseg;
  logic [3:0] rightseg;

  int checks = 0;
  int errors = 0;

  int m_cnt;
  int m_hist[$];
  bit m_have;
  int m_last;
  int m_k;

  logic [7:0] pat_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                               8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
  int pow10 [4] = '{1, 10, 100, 1000};

  priority_decode_display #(.SCAN_DIV(4)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .n_EN         (n_EN),
    .code_valid   (code_valid),
    .code         (code),
    .code_ready   (code_ready),
    .led          (led),
    .a_to_g_left  (a_to_g_left),
    .a_to_g_right (a_to_g_right),
    .leftseg      (leftseg),
    .rightseg     (rightseg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_hist.delete();
    m_have = 1'b0;
    m_last = 0;
    m_k    = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("rst_led",      led,               8'h00);
    chk("rst_left",     a_to_g_left,       8'h00);
    chk("rst_right",    a_to_g_right,      8'h00);
    chk("rst_leftseg",  {4'h0, leftseg},   8'h01);
    chk("rst_rightseg", {4'h0, rightseg},  8'h01);
    model_reset();
    @(posedge clk);
    #2 n_rst = 1'b1;
  endtask

  task automatic step(input bit v, input logic [2:0] c, input bit en_n);
    logic [7:0] e_led, e_l, e_r;
    logic [3:0] e_sel;
    int         idx;
    bit         xfer;
    @(negedge clk);
    code_valid = v;
    code       = c;
    n_EN       = en_n;
    #1;
    chk("code_ready", {7'd0, code_ready}, {7'd0, ~en_n});
    xfer  = v && !en_n;
    idx   = ((m_k + 1) / 4) % 4;
    e_sel = 4'(1 << idx);
    if (en_n) begin
      e_led = 8'h00;
      e_l   = 8'h00;
      e_r   = 8'h00;
    end else begin
      if (xfer)        e_led = 8'(1 << c);
      else if (m_have) e_led = 8'(1 << m_last);
      else             e_led = 8'h00;
      e_l = pat_tab[(m_cnt / pow10[idx]) % 10];
      e_r = (idx < m_hist.size()) ? pat_tab[m_hist[idx]] : 8'h00;
`ifdef DP_NEWEST_EN
      if (idx == 0 && m_hist.size() > 0) e_r[0] = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
    chk("led",      led,              e_led);
    chk("left",     a_to_g_left,      e_l);
    chk("right",    a_to_g_right,     e_r);
    chk("leftseg",  {4'h0, leftseg},  {4'h0, e_sel});
    chk("rightseg", {4'h0, rightseg}, {4'h0, e_sel});
    m_k++;
    if (xfer) begin
      m_hist.push_front(int'(c));
      if (m_hist.size() > 4) void'(m_hist.pop_back());
      m_cnt  = (m_cnt + 1) % 10000;
      m_have = 1'b1;
      m_last = int'(c);
    end
  endtask

  task automatic idle(input int n, input bit en_n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, en_n);
  endtask

  initial begin
    model_reset();
    apply_reset();

    // Select scanning and wrap from reset with nothing accepted.
    idle(20, 1'b0);

    // Codes 5, 2, 7 then a full scan of both groups.
    step(1'b1, 3'd5, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    step(1'b1, 3'd7, 1'b0);
    idle(16, 1'b0);

    // Disabled block ignores offered codes; state reappears afterwards.
    for (int i = 0; i < 6; i++) step(1'b1, 3'd3, 1'b1);
    idle(16, 1'b0);

    // Randomized traffic with enable toggling mid-scan.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0));

    // Reset mid-stream after two transfers.
    step(1'b1, 3'd4, 1'b0);
    step(1'b1, 3'd6, 1'b0);
    apply_reset();
    step(1'b1, 3'd3, 1'b0);
    idle(16, 1'b0);

    // Count wrap: 10000 transfers of code 1 from a cleared count.
    apply_reset();
    for (int i = 0; i < 10000; i++) step(1'b1, 3'd1, 1'b0);
    idle(16, 1'b0);

    // Newest-digit dp behaviour after a single code 0.
    apply_reset();
    step(1'b1, 3'd0, 1'b0);
    idle(16, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
